// File: rtl/aont_pkg.sv
// rtl/aont_pkg.sv - shared types, FSM state codes and latin-square helpers for the AONT engine
//
// Purpose: default geometry, symbol/block typedefs, FSM state encodings and the
//          latin-square product / quotient used by the lanes and the leader chain.
// Ports:   none (package).

package aont_pkg;

   localparam int SYMW_DEF  = 4;
   localparam int LSLEN_DEF = 16;

   typedef logic [SYMW_DEF-1:0] sym_t;
   typedef sym_t [LSLEN_DEF-1:0] blk_t;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LEADER = 2'd1;
   localparam logic [1:0] BLOCKS = 2'd2;
   localparam logic [1:0] TAIL   = 2'd3;

   // L[r][c] = ((r + c) mod 2**w) ^ x
   function automatic int unsigned ls_mul(input int unsigned r, input int unsigned c,
                                          input int unsigned x, input int unsigned w);
      int unsigned mask;
      mask = (32'd1 << w) - 32'd1;
      return ((r + c) & mask) ^ (x & mask);
   endfunction

   // Row recovery: the r with L[r][c] == e, i.e. ((e ^ x) - c) mod 2**w
   function automatic int unsigned ls_div(input int unsigned e, input int unsigned c,
                                          input int unsigned x, input int unsigned w);
      int unsigned mask;
      mask = (32'd1 << w) - 32'd1;
      return ((e ^ x) - c) & mask;
   endfunction

endpackage

// File: rtl/latin_square_lane.sv
// rtl/latin_square_lane.sv - one-symbol latin-square combine lane
//
// Purpose: per-symbol combinational encode/decode and accumulator update.
// Ports:   x        in  input symbol (plaintext when encoding, ciphertext when decoding)
//          col      in  column symbol, leader symbol xor block index
//          acc      in  current accumulator symbol
//          mode     in  0=encode, 1=decode
//          res      out output symbol (ciphertext or recovered plaintext)
//          acc_next out accumulator folded with the ciphertext symbol

module latin_square_lane import aont_pkg::*; #(
   parameter int              SYMW   = SYMW_DEF,
   parameter logic [SYMW-1:0] LS_XOR = '0
) (
   input  logic [SYMW-1:0] x,
   input  logic [SYMW-1:0] col,
   input  logic [SYMW-1:0] acc,
   input  logic            mode,
   output logic [SYMW-1:0] res,
   output logic [SYMW-1:0] acc_next
);

   logic [SYMW-1:0] enc;
   logic [SYMW-1:0] dec;
   logic [SYMW-1:0] ciph;

   assign enc = SYMW'(ls_mul(32'(x), 32'(col), 32'(LS_XOR), 32'(SYMW)));
   assign dec = SYMW'(ls_div(32'(x), 32'(col), 32'(LS_XOR), 32'(SYMW)));
   assign res = mode ? dec : enc;

   // The accumulator always absorbs ciphertext so both directions end on the same tail.
   assign ciph     = mode ? x : enc;
   assign acc_next = SYMW'(ls_mul(32'(acc), 32'(ciph), 32'(LS_XOR), 32'(SYMW)));

endmodule

// File: rtl/aont_ls_engine.sv
// rtl/aont_ls_engine.sv - latin-square all-or-nothing transform engine (top)
//
// Purpose: expands the key into a leader sequence, streams NBLK blocks through the
//          latin-square lanes and appends (encode) or checks (decode) the tail block.
// Ports:   clk, rst                        clock, async active-high reset
//          start, mode, key                transform request, captured in IDLE
//          in_valid, in_ready, in_data     input block stream
//          out_valid, out_ready, out_data,
//          out_last                        output block stream
//          busy, done, tail_err            status

module aont_ls_engine import aont_pkg::*; #(
   parameter int              SYMW   = SYMW_DEF,
   parameter int              LSLEN  = LSLEN_DEF,
   parameter int              NBLK   = 8,
   parameter logic [SYMW-1:0] LS_XOR = SYMW'(5)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [LSLEN*SYMW-1:0] key,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LSLEN*SYMW-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LSLEN*SYMW-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  tail_err
);

   localparam int W  = LSLEN * SYMW;
   localparam int BW = $clog2(NBLK + 1);
   localparam int LW = $clog2(LSLEN);

   logic [1:0]      state;
   logic            mode_r;
   logic [W-1:0]    key_r;
   logic [W-1:0]    ld;
   logic [W-1:0]    acc;
   logic [BW-1:0]   blk;
   logic [LW-1:0]   lcnt;
   logic            tail_sent;

   logic [SYMW-1:0] c;
   logic [SYMW-1:0] ld_new;
   logic [W-1:0]    res;
   logic [W-1:0]    acc_nxt;
   logic [W-1:0]    tail_exp;
   logic            out_free;
   logic            fire;
   logic            last_blk;

   assign busy     = (state != IDLE);
   assign out_free = !out_valid || out_ready;
   assign in_ready = ((state == BLOCKS) || ((state == TAIL) && mode_r)) && out_free;
   assign fire     = in_valid && in_ready;
   assign last_blk = (blk == BW'(NBLK - 1));
   assign c        = SYMW'(blk);
   assign tail_exp = acc ^ ld;

   // The leader is built in a shift register: the newest symbol enters at the top,
   // so after LSLEN-1 shifts ld[j] sits in symbol slot j.
   assign ld_new = SYMW'(ls_mul(32'(key_r[int'(lcnt)*SYMW +: SYMW]), 32'(ld[W-1 -: SYMW]),
                                32'(LS_XOR), 32'(SYMW)));

   for (genvar j = 0; j < LSLEN; j++) begin : g_lane
      latin_square_lane #(.SYMW(SYMW), .LS_XOR(LS_XOR)) u_lane (
         .x        (in_data[j*SYMW +: SYMW]),
         .col      (ld[j*SYMW +: SYMW] ^ c),
         .acc      (acc[j*SYMW +: SYMW]),
         .mode     (mode_r),
         .res      (res[j*SYMW +: SYMW]),
         .acc_next (acc_nxt[j*SYMW +: SYMW])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode_r    <= 1'b0;
         key_r     <= '0;
         ld        <= '0;
         acc       <= '0;
         blk       <= '0;
         lcnt      <= '0;
         tail_sent <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         tail_err  <= 1'b0;
      end else begin
         done <= 1'b0;
         // Drain the output register; a reload below in the same cycle takes precedence.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  mode_r    <= mode;
                  key_r     <= key;
                  acc       <= key;
                  ld        <= {key[SYMW-1:0], {(W-SYMW){1'b0}}};
                  lcnt      <= LW'(1);
                  blk       <= '0;
                  tail_sent <= 1'b0;
                  tail_err  <= 1'b0;
                  state     <= LEADER;
               end
            end
            LEADER: begin
               ld   <= {ld_new, ld[W-1:SYMW]};
               lcnt <= lcnt + LW'(1);
               if (lcnt == LW'(LSLEN - 1)) state <= BLOCKS;
            end
            BLOCKS: begin
               if (fire) begin
                  out_valid <= 1'b1;
                  out_data  <= res;
                  out_last  <= mode_r && last_blk;
                  acc       <= acc_nxt;
                  blk       <= blk + BW'(1);
                  if (last_blk) state <= TAIL;
               end
            end
            TAIL: begin
               if (!mode_r) begin
                  if (!tail_sent && out_free) begin
                     out_valid <= 1'b1;
                     out_data  <= tail_exp;
                     out_last  <= 1'b1;
                     tail_sent <= 1'b1;
                  end else if (tail_sent && out_valid && out_ready) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end else if (fire) begin
                  tail_err <= (in_data != tail_exp);
                  done     <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aont_ls_engine.sv
// tb/tb_aont_ls_engine.sv - directed self-checking bench for aont_ls_engine

module tb_aont_ls_engine;

   localparam int SYMW  = 4;
   localparam int LSLEN = 16;
   localparam int NBLK  = 8;
   localparam int W     = LSLEN * SYMW;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, mode, in_valid, out_ready;
   logic [W-1:0] key, in_data;

   logic         in_ready, out_valid, out_last, busy, done, tail_err;
   logic [W-1:0] out_data;
   logic         in_ready5, out_valid5, out_last5, busy5, done5, tail_err5;
   logic [W-1:0] out_data5;

   always #5 clk = ~clk;

   aont_ls_engine #(.SYMW(SYMW), .LSLEN(LSLEN), .NBLK(NBLK), .LS_XOR(4'd0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .tail_err(tail_err)
   );

   aont_ls_engine #(.SYMW(SYMW), .LSLEN(LSLEN), .NBLK(NBLK), .LS_XOR(4'd5)) dut5 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
      .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
      .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5), .out_last(out_last5),
      .busy(busy5), .done(done5), .tail_err(tail_err5)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0] src [0:NBLK];
   logic [W-1:0] msg [0:NBLK-1];
   logic [W-1:0] got [$];
   logic         got_l [$];
   logic [W-1:0] got5 [$];
   int           done_n, done_cyc, last_cyc;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rep(input logic [3:0] s);
      return {LSLEN{s}};
   endfunction

   // One transform: start, then offer blocks every cycle (also during LEADER) until done.
   task automatic run(input logic m, input logic [W-1:0] k, input bit bp, input bit spam);
      int sent = 0;
      int cy = 0;
      int nin;
      bit stall = 1'b0;
      logic [W-1:0] held = '0;
      nin = m ? NBLK + 1 : NBLK;
      got.delete(); got_l.delete(); got5.delete();
      done_n = 0; done_cyc = -10; last_cyc = -1;
      @(negedge clk);
      start = 1'b1; mode = m; key = k; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cy < 200 && (done_n == 0 || cy <= done_cyc + 2)) begin
         @(negedge clk);
         out_ready = bp ? ((cy % 4) == 0 || (cy % 4) == 3) : 1'b1;
         in_valid  = (sent < nin);
         in_data   = src[(sent <= NBLK) ? sent : NBLK];
         start     = spam && (cy == 3 || cy == 12 || cy == 20);
         key       = spam ? ~k : k;
         mode      = spam ? ~m : m;
         #1;
         if (cy == 0) begin
            chk("leader_busy", W'(busy), W'(1'b1));
            chk("leader_in_ready", W'(in_ready), W'(1'b0));
            chk("tail_err_cleared", W'(tail_err), W'(1'b0));
         end
         if (stall) begin
            chk("stall_valid", W'(out_valid), W'(1'b1));
            chk("stall_data", out_data, held);
         end
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_l.push_back(out_last);
            got5.push_back(out_data5);
            if (out_last && !m) last_cyc = cy;
         end
         stall = out_valid && !out_ready;
         held  = out_data;
         if (in_valid && in_ready) begin
            if (sent == NBLK) last_cyc = cy;
            sent++;
         end
         if (done) begin
            done_n++;
            done_cyc = cy;
         end
         cy++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("done_pulses", W'(done_n), W'(1));
      chk("done_timing", W'(done_cyc), W'(last_cyc + 1));
   endtask

   task automatic check_enc(input logic [3:0] bx, input logic [W-1:0] tail_e);
      chk("enc_beats", W'(got.size()), W'(NBLK + 1));
      for (int i = 0; i < NBLK; i++) begin
         if (i < got.size()) begin
            chk($sformatf("enc_blk%0d", i), got[i], rep(4'(i) ^ bx));
            chk($sformatf("enc_last%0d", i), W'(got_l[i]), W'(1'b0));
         end
      end
      if (got.size() > NBLK) begin
         chk("enc_tail", got[NBLK], tail_e);
         chk("enc_tail_last", W'(got_l[NBLK]), W'(1'b1));
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_in_ready"}, W'(in_ready), W'(1'b0));
      chk({tag, "_out_valid"}, W'(out_valid), W'(1'b0));
      chk({tag, "_out_last"}, W'(out_last), W'(1'b0));
      chk({tag, "_busy"}, W'(busy), W'(1'b0));
      chk({tag, "_done"}, W'(done), W'(1'b0));
      chk({tag, "_tail_err"}, W'(tail_err), W'(1'b0));
      chk({tag, "_out_data"}, out_data, '0);
   endtask

   initial begin
      logic [W-1:0] ct [0:NBLK];
      int sent;

      rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      for (int i = 0; i <= NBLK; i++) src[i] = '0;
      repeat (2) @(negedge clk);
      #1;
      check_idle_zero("reset");
      rst = 1'b0;

      // Encode, zero key and data: blocks carry i, tail 0xC.
      run(1'b0, '0, 1'b0, 1'b0);
      check_enc(4'h0, rep(4'hC));
      for (int i = 0; i <= NBLK; i++) ct[i] = (i < got.size()) ? got[i] : '0;

      // Decode that stream back to zeros.
      for (int i = 0; i <= NBLK; i++) src[i] = ct[i];
      run(1'b1, '0, 1'b0, 1'b0);
      chk("dec_beats", W'(got.size()), W'(NBLK));
      for (int i = 0; i < NBLK; i++) begin
         if (i < got.size()) begin
            chk($sformatf("dec_blk%0d", i), got[i], '0);
            chk($sformatf("dec_last%0d", i), W'(got_l[i]), W'(i == NBLK - 1));
         end
      end
      chk("dec_tail_ok", W'(tail_err), W'(1'b0));

      // One corrupted tail symbol.
      src[NBLK] = ct[NBLK] ^ 64'h1;
      run(1'b1, '0, 1'b0, 1'b0);
      chk("dec_tail_bad", W'(tail_err), W'(1'b1));

      // Backpressure 1-0-0-1 yields the same stream.
      for (int i = 0; i <= NBLK; i++) src[i] = '0;
      run(1'b0, '0, 1'b1, 1'b0);
      check_enc(4'h0, rep(4'hC));

      // k[0]=1: leader all 1, blocks 1^i, acc[0]=13 others 12, tail C then D's.
      run(1'b0, 64'h1, 1'b0, 1'b0);
      check_enc(4'h1, 64'hDDDD_DDDD_DDDD_DDDC);

      // Reset while block 3 is in flight.
      @(negedge clk);
      start = 1'b1; mode = 1'b0; key = '0;
      @(negedge clk);
      start = 1'b0;
      sent = 0;
      for (int cy = 0; cy < 100 && sent < 3; cy++) begin
         @(negedge clk);
         out_ready = 1'b1; in_valid = 1'b1; in_data = '0;
         #1;
         if (in_valid && in_ready) sent++;
      end
      chk("abort_reached_blk3", W'(sent), W'(3));
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_idle_zero("abort");
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("abort_no_done", W'(done), W'(1'b0));
      end
      run(1'b0, '0, 1'b0, 1'b0);
      check_enc(4'h0, rep(4'hC));

      // start pulses while busy and in_valid during LEADER are ignored.
      run(1'b0, '0, 1'b0, 1'b1);
      check_enc(4'h0, rep(4'hC));

      // Round trip on the LS_XOR=5 instance.
      for (int r = 0; r < 100; r++) begin
         logic [W-1:0] k;
         k = {$urandom, $urandom};
         for (int i = 0; i < NBLK; i++) begin
            msg[i] = {$urandom, $urandom};
            src[i] = msg[i];
         end
         src[NBLK] = '0;
         run(1'b0, k, r[0], 1'b0);
         chk("rt_enc_beats", W'(got5.size()), W'(NBLK + 1));
         for (int i = 0; i <= NBLK; i++) src[i] = (i < got5.size()) ? got5[i] : '0;
         run(1'b1, k, r[1], 1'b0);
         for (int i = 0; i < NBLK; i++) begin
            if (i < got5.size()) chk($sformatf("rt%0d_blk%0d", r, i), got5[i], msg[i]);
         end
         chk($sformatf("rt%0d_tail_err", r), W'(tail_err5), W'(1'b0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
